// File: rtl/sub8u_pkg.sv
// Shared types and default sizing for the sub8u_serial digit-serial subtractor.
package sub8u_pkg;

  localparam int SUB_WIDTH    = 8;
  localparam int SUB_DIGIT    = 2;
  localparam int SUB_APPROX_K = 2;

  localparam int SUB_N     = SUB_WIDTH / SUB_DIGIT;
  localparam int SUB_CNT_W = (SUB_N > 1) ? $clog2(SUB_N) : 1;
  localparam int SUB_RES_W = SUB_WIDTH + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/sub_digit_cell.sv
// Combinational DIGIT-bit ripple-borrow subtractor: {bout, d} = a - b - bin.
module sub_digit_cell #(
  parameter int DIGIT = 2
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             bin,
  output logic [DIGIT-1:0] d,
  output logic             bout
);

  // NOTE: blocking assignments here build a combinational ripple chain; the
  // local borrow is fully rewritten each evaluation, so no latch can form.
  always_comb begin
    logic br;
    br = bin;
    d  = '0;
    for (int i = 0; i < DIGIT; i++) begin
      d[i] = a[i] ^ b[i] ^ br;
      br   = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & br);
    end
    bout = br;
  end

endmodule

// File: rtl/sub8u_serial.sv
// Digit-serial unsigned subtractor, O = {borrow, A - B}, DIGIT bits per RUN cycle.
// Optional macro SUB8U_APPROX_LSB_EN truncates the APPROX_K low bits of B.
module sub8u_serial
  import sub8u_pkg::*;
#(
  parameter int WIDTH    = SUB_WIDTH,
  parameter int DIGIT    = SUB_DIGIT,
  parameter int APPROX_K = SUB_APPROX_K
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   O
);

  localparam int N_DIG = WIDTH / DIGIT;
  localparam int CNT_W = (N_DIG > 1) ? $clog2(N_DIG) : 1;
  localparam int RES_W = WIDTH + 1;

  state_t state, state_nxt;

  logic [CNT_W-1:0] cnt;
  logic             borrow;
  logic [WIDTH-1:0] a_q, b_q;
  logic [RES_W-1:0] o_q;
  logic [DIGIT-1:0] dig_d;
  logic             dig_bout;
  logic             last;

  assign last      = (cnt == CNT_W'(N_DIG - 1));
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign O         = o_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (in_valid)  state_nxt = RUN;
      RUN:     if (last)      state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Single cell shared by every digit; the counter selects which slice it sees.
  sub_digit_cell #(.DIGIT(DIGIT)) u_cell (
    .a    (a_q[cnt*DIGIT +: DIGIT]),
    .b    (b_q[cnt*DIGIT +: DIGIT]),
    .bin  (borrow),
    .d    (dig_d),
    .bout (dig_bout)
  );

  // NOTE: state-holding registers use non-blocking assignments so every
  // register samples pre-edge values; all of them reset, including operands.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt    <= '0;
      borrow <= 1'b0;
      a_q    <= '0;
      b_q    <= '0;
      o_q    <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          a_q    <= A;
`ifdef SUB8U_APPROX_LSB_EN
          // Zeroed low subtrahend bits pass A through and create no borrow.
          b_q    <= B & ({WIDTH{1'b1}} << APPROX_K);
`else
          b_q    <= B;
`endif
          cnt    <= '0;
          borrow <= 1'b0;
        end
        RUN: begin
          o_q[cnt*DIGIT +: DIGIT] <= dig_d;
          borrow                  <= dig_bout;
          cnt                     <= cnt + 1'b1;
          if (last) o_q[WIDTH] <= dig_bout;
        end
        default: ;
      endcase
    end
  end

endmodule
